// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory bus: load/store priority with a
// fetch anti-starvation guard, and an owner FIFO that routes in-order responses back.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,

    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [1:0]      ls_size,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            rsp_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STK_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [STK_W-1:0] LIMIT_C  = STK_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    logic [DEPTH-1:0] owner_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STK_W-1:0] streak;

    logic full;
    logic sel_if;
    logic accept;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // full looks only at the registered count, so a pop never frees a slot in its own cycle.
    assign full    = (count == DEPTH_C);
    assign mem_req = (if_req | ls_req) & ~full;
    assign sel_if  = if_req & (~ls_req | (streak == LIMIT_C));
    assign accept  = mem_req & mem_gnt;
    assign if_gnt  = accept & sel_if;
    assign ls_gnt  = accept & ~sel_if;

    assign pop       = mem_rvalid & (count != '0);
    assign head      = owner_q[rd_ptr];
    assign if_rvalid = pop & (head == OWNER_IF);
    assign ls_rvalid = pop & (head == OWNER_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mem_we    = ls_we;
        mem_size  = ls_size;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        if (sel_if) begin
            mem_we    = 1'b0;
            mem_size  = 2'b10;
            mem_addr  = if_addr;
            mem_wdata = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_rvalid && (count == '0)) begin
                rsp_err <= 1'b1;
            end
        end
    end

    // NOTE: owner storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[wr_ptr] <= ~sel_if;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (ls_gnt && if_req) begin
            if (streak != LIMIT_C) begin
                streak <= streak + 1'b1;
            end
        end else if (if_gnt || !if_req) begin
            streak <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: owner expectations are queued at each grant
// and popped when a response is driven, checked with immediate assertions.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req;
    logic            ls_we;
    logic [1:0]      ls_size;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rsp_err;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic exp_if;

    mem_port_arbiter #(.XLEN(XLEN), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_size    = 2'b10;
        ls_addr    = '0;
        ls_wdata   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Pops the expected owner for the response currently on the bus and checks its routing.
    task automatic check_rsp(input logic [31:0] data);
        logic owner;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=response expected=none");
        end else begin
            owner = exp_q.pop_front();
            check("if_rvalid", if_rvalid, owner == 1'b0);
            check("ls_rvalid", ls_rvalid, owner == 1'b1);
            if (owner) check("ls_rdata", ls_rdata, data);
            else       check("if_rdata", if_rdata, data);
        end
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        #3;
        check_rsp(data);
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #3;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_ls_gnt", ls_gnt, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_ls_rvalid", ls_rvalid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_rsp_err", rsp_err, 0);
        tick();

        // Single fetch, response two cycles after grant.
        if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
        #3;
        check("fetch_mem_req", mem_req, 1);
        check("fetch_if_gnt", if_gnt, 1);
        check("fetch_ls_gnt", ls_gnt, 0);
        check("fetch_addr", mem_addr, 32'h100);
        check("fetch_we", mem_we, 0);
        check("fetch_size", mem_size, 2'b10);
        check("fetch_wdata", mem_wdata, 0);
        exp_q.push_back(1'b0);
        tick();
        if_req = 1'b0; mem_gnt = 1'b0;
        tick();
        respond(32'hDEADBEEF);

        // Contention: both requesting, latency-1 responses keep count at 1 (accept+pop each cycle).
        for (int i = 0; i < 10; i++) begin
            if_req = 1'b1; if_addr = 32'h104;
            ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
            mem_gnt    = 1'b1;
            mem_rvalid = (i > 0);
            mem_rdata  = 32'h1000 + i;
            #3;
            exp_if = (i % 5 == 4);
            check($sformatf("cont_if_gnt_%0d", i), if_gnt, exp_if);
            check($sformatf("cont_ls_gnt_%0d", i), ls_gnt, !exp_if);
            check($sformatf("cont_addr_%0d", i), mem_addr, exp_if ? 32'h104 : 32'h200);
            if (i > 0) check_rsp(32'h1000 + i);
            exp_q.push_back(!exp_if);
            tick();
        end
        idle();
        respond(32'h2000);

        // Full: two store grants, then blocked until the cycle after a response.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'hA5; mem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            check($sformatf("full_fill_gnt_%0d", i), ls_gnt, 1);
            exp_q.push_back(1'b1);
            tick();
        end
        if_req = 1'b1; if_addr = 32'h108;
        #3;
        check("full_mem_req", mem_req, 0);
        check("full_if_gnt", if_gnt, 0);
        check("full_ls_gnt", ls_gnt, 0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h33;
        #3;
        check("full_pop_mem_req", mem_req, 0);
        check("full_pop_ls_gnt", ls_gnt, 0);
        check_rsp(32'h33);
        tick();
        mem_rvalid = 1'b0; ls_req = 1'b0;
        #3;
        check("full_after_if_gnt", if_gnt, 1);
        exp_q.push_back(1'b0);
        tick();
        idle();
        respond(32'h44);
        respond(32'h45);

        // Ordering: fetch then byte store, responses routed in grant order.
        if_req = 1'b1; if_addr = 32'h400; mem_gnt = 1'b1;
        #3;
        check("ord_if_gnt", if_gnt, 1);
        exp_q.push_back(1'b0);
        tick();
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h404; ls_wdata = 32'hCAFE;
        #3;
        check("ord_ls_gnt", ls_gnt, 1);
        check("ord_mem_we", mem_we, 1);
        check("ord_mem_size", mem_size, 2'b00);
        check("ord_mem_wdata", mem_wdata, 32'hCAFE);
        exp_q.push_back(1'b1);
        tick();
        idle();
        respond(32'h11);
        respond(32'h22);

        // Error: response with nothing outstanding sets a sticky flag and routes nothing.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        #3;
        check("err_if_rvalid", if_rvalid, 0);
        check("err_ls_rvalid", ls_rvalid, 0);
        tick();
        mem_rvalid = 1'b0;
        #3;
        check("err_set", rsp_err, 1);
        tick();
        check("err_held", rsp_err, 1);

        // Grant in flight at reset is forgotten.
        if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
        #3;
        check("inflight_if_gnt", if_gnt, 1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        check("rst2_rsp_err", rsp_err, 0);
        check("rst2_mem_req", mem_req, 0);

        // Stale response concurrent with a fresh accept: error, no routing, accept still counted.
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        if_req = 1'b1; if_addr = 32'h600; mem_gnt = 1'b1;
        #3;
        check("stale_if_gnt", if_gnt, 1);
        check("stale_if_rvalid", if_rvalid, 0);
        check("stale_ls_rvalid", ls_rvalid, 0);
        exp_q.push_back(1'b0);
        tick();
        idle();
        #3;
        check("stale_err", rsp_err, 1);
        respond(32'h55);

        // After reset the count restarts at 0: exactly two grants fit.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        check("rst3_rsp_err", rsp_err, 0);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h700; mem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            check($sformatf("rst3_gnt_%0d", i), ls_gnt, 1);
            exp_q.push_back(1'b1);
            tick();
        end
        #3;
        check("rst3_full", mem_req, 0);
        idle();
        tick();
        respond(32'h66);
        respond(32'h67);
        check("final_rsp_err", rsp_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
